// File: rtl/pingpangpung_ctrl_pkg.sv
// Shared definitions for the ping/pang/pung buffer ownership controller.
//   - buf_state_e : per-buffer lifecycle codes (also the debug encoding on buf_state)
//   - SEL_*       : agent-side select encoding (00 none, 01 ping, 10 pang, 11 pung)
//   - idx2sel / sel2idx : conversion between buffer index 0..2 and select code
package pingpangpung_ctrl_pkg;

    localparam int NUM_BUFS = 3;

    typedef enum logic [2:0] {
        ST_EMPTY    = 3'd0,
        ST_SNOOP    = 3'd1,
        ST_FILLED   = 3'd2,
        ST_CPU      = 3'd3,
        ST_ACCEPTED = 3'd4,
        ST_FWD      = 3'd5
    } buf_state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_PING = 2'b01;
    localparam logic [1:0] SEL_PANG = 2'b10;
    localparam logic [1:0] SEL_PUNG = 2'b11;

    function automatic logic [1:0] idx2sel(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

    function automatic logic [1:0] sel2idx(input logic [1:0] sel);
        return sel - 2'd1;
    endfunction

endpackage

// File: rtl/pingpangpung_ctrl_bufidx_fifo.sv
// Small circular FIFO of buffer indices, used to keep packet arrival order
// between the snooper and CPU (cpu_fifo) and between CPU and forwarder (fwd_fifo).
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_push, i_din   : enqueue i_din
//   i_pop           : drop the head entry (push and pop together are legal)
//   o_head          : current head entry (valid when !o_empty)
//   o_empty, o_count: occupancy
module bufidx_fifo #(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= ptr_inc(r_wr);
            end
            if (i_pop) r_rd <= ptr_inc(r_rd);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !i_pop && r_count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_pop && o_empty));

endmodule

// File: rtl/pingpangpung_ctrl.sv
// Ownership controller for the three packet buffers (ping/pang/pung) shared
// by the snooper, CPU and forwarder. Each buffer walks
// EMPTY -> SNOOP -> FILLED -> CPU -> (ACCEPTED -> FWD ->) EMPTY.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   sn_done                   : snooper finished its buffer
//   cpu_acc / cpu_rej         : CPU verdict on its buffer (both = reject)
//   fwd_done                  : forwarder drained its buffer
//   sn_sel/cpu_sel/fwd_sel    : buffer owned by each agent (00 none, 01..11 ping..pung)
//   sn_rdy/cpu_rdy/fwd_rdy    : agent owns a buffer
//   buf_state                 : {pung,pang,ping} 3-bit state codes (debug)
module pingpangpung_ctrl
    import pingpangpung_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sn_done,
    input  logic       cpu_acc,
    input  logic       cpu_rej,
    input  logic       fwd_done,
    output logic [1:0] sn_sel,
    output logic [1:0] cpu_sel,
    output logic [1:0] fwd_sel,
    output logic       sn_rdy,
    output logic       cpu_rdy,
    output logic       fwd_rdy,
    output logic [8:0] buf_state
);

    buf_state_e r_state     [NUM_BUFS];
    buf_state_e w_state_nxt [NUM_BUFS];

    logic [1:0] r_sn_sel, r_cpu_sel, r_fwd_sel;
    logic [1:0] w_sn_sel_nxt, w_cpu_sel_nxt, w_fwd_sel_nxt;
    logic       r_sn_rdy, r_cpu_rdy, r_fwd_rdy;

    logic       w_sn_rel, w_cpu_rel, w_cpu_fwd, w_fwd_rel;
    logic       w_sn_claim, w_cpu_claim, w_fwd_claim;
    logic       w_any_empty;
    logic [1:0] w_sn_pick;

    logic [1:0] w_cpu_head, w_fwd_head;
    logic       w_cpu_empty, w_fwd_empty;
    logic [1:0] w_cpu_cnt, w_fwd_cnt;

    // Releases act on the buffer currently named by the agent's sel;
    // pulses while sel is NONE fall out here and are ignored.
    assign w_sn_rel  = sn_done && (r_sn_sel != SEL_NONE);
    assign w_cpu_rel = (cpu_acc || cpu_rej) && (r_cpu_sel != SEL_NONE);
    assign w_cpu_fwd = w_cpu_rel && cpu_acc && !cpu_rej;
    assign w_fwd_rel = fwd_done && (r_fwd_sel != SEL_NONE);

    // Lowest-index EMPTY buffer, from registered state only, so a buffer
    // freed this edge is not handed out until the next one.
    always_comb begin
        w_any_empty = 1'b0;
        w_sn_pick   = 2'd0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (r_state[i] == ST_EMPTY) begin
                w_any_empty = 1'b1;
                w_sn_pick   = 2'(i);
            end
        end
    end

    assign w_sn_claim  = (r_sn_sel  == SEL_NONE) && w_any_empty;
    assign w_cpu_claim = (r_cpu_sel == SEL_NONE) && !w_cpu_empty;
    assign w_fwd_claim = (r_fwd_sel == SEL_NONE) && !w_fwd_empty;

    bufidx_fifo #(.DEPTH(NUM_BUFS), .WIDTH(2)) u_cpu_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_sn_rel),
        .i_din   (sel2idx(r_sn_sel)),
        .i_pop   (w_cpu_claim),
        .o_head  (w_cpu_head),
        .o_empty (w_cpu_empty),
        .o_count (w_cpu_cnt)
    );

    bufidx_fifo #(.DEPTH(NUM_BUFS), .WIDTH(2)) u_fwd_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_cpu_fwd),
        .i_din   (sel2idx(r_cpu_sel)),
        .i_pop   (w_fwd_claim),
        .o_head  (w_fwd_head),
        .o_empty (w_fwd_empty),
        .o_count (w_fwd_cnt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUFS; i++) r_state[i] <= ST_EMPTY;
            r_sn_sel  <= SEL_NONE;
            r_cpu_sel <= SEL_NONE;
            r_fwd_sel <= SEL_NONE;
            r_sn_rdy  <= 1'b0;
            r_cpu_rdy <= 1'b0;
            r_fwd_rdy <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BUFS; i++) r_state[i] <= w_state_nxt[i];
            r_sn_sel  <= w_sn_sel_nxt;
            r_cpu_sel <= w_cpu_sel_nxt;
            r_fwd_sel <= w_fwd_sel_nxt;
            r_sn_rdy  <= (w_sn_sel_nxt  != SEL_NONE);
            r_cpu_rdy <= (w_cpu_sel_nxt != SEL_NONE);
            r_fwd_rdy <= (w_fwd_sel_nxt != SEL_NONE);
        end
    end

    // Next-state: every event in a cycle targets a distinct buffer, so the
    // per-event writes below never overlap.
    always_comb begin
        for (int i = 0; i < NUM_BUFS; i++) w_state_nxt[i] = r_state[i];
        if (w_sn_rel)    w_state_nxt[sel2idx(r_sn_sel)]  = ST_FILLED;
        if (w_cpu_rel)   w_state_nxt[sel2idx(r_cpu_sel)] = w_cpu_fwd ? ST_ACCEPTED : ST_EMPTY;
        if (w_fwd_rel)   w_state_nxt[sel2idx(r_fwd_sel)] = ST_EMPTY;
        if (w_sn_claim)  w_state_nxt[w_sn_pick]  = ST_SNOOP;
        if (w_cpu_claim) w_state_nxt[w_cpu_head] = ST_CPU;
        if (w_fwd_claim) w_state_nxt[w_fwd_head] = ST_FWD;

        w_sn_sel_nxt  = w_sn_rel  ? SEL_NONE : (w_sn_claim  ? idx2sel(w_sn_pick)  : r_sn_sel);
        w_cpu_sel_nxt = w_cpu_rel ? SEL_NONE : (w_cpu_claim ? idx2sel(w_cpu_head) : r_cpu_sel);
        w_fwd_sel_nxt = w_fwd_rel ? SEL_NONE : (w_fwd_claim ? idx2sel(w_fwd_head) : r_fwd_sel);
    end

    // Outputs
    always_comb begin
        sn_sel    = r_sn_sel;
        cpu_sel   = r_cpu_sel;
        fwd_sel   = r_fwd_sel;
        sn_rdy    = r_sn_rdy;
        cpu_rdy   = r_cpu_rdy;
        fwd_rdy   = r_fwd_rdy;
        buf_state = {r_state[2], r_state[1], r_state[0]};
    end

    a_no_collision: assert property (@(posedge clk) disable iff (rst)
        !((r_sn_sel  != SEL_NONE && (r_sn_sel == r_cpu_sel || r_sn_sel == r_fwd_sel)) ||
          (r_cpu_sel != SEL_NONE && r_cpu_sel == r_fwd_sel)));

    // A buffer index can be queued in at most one FIFO at a time.
    a_queued_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, w_cpu_cnt} + {1'b0, w_fwd_cnt}) <= 3'd3);

endmodule
